l1_fill_buffer: RTL and testbench

L1_FILL_BUFFER -- requirements
Module: l1_fill_buffer

---
 rtl/l1_fill_buffer_pkg.sv | 19 +
 rtl/l1_fill_buffer.sv | 115 +++++++++++
 tb/tb_l1_fill_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/l1_fill_buffer_pkg.sv
// rtl/l1_fill_buffer_pkg.sv - shared L1 cache geometry and fill FSM state encoding
package l1_fill_buffer_pkg;

  localparam int L1_LINE_BITS   = 1024;
  localparam int L1_BEAT_BITS   = 64;
  localparam int L1_INDEX_BITS  = 8;
  localparam int L1_ADDR_BITS   = 32;
  localparam int L1_BEATS       = L1_LINE_BITS / L1_BEAT_BITS;
  localparam int L1_OFFSET_BITS = $clog2(L1_LINE_BITS / 8);

  typedef enum logic [2:0] {
    FB_IDLE  = 3'd0,
    FB_MREQ  = 3'd1,
    FB_FILL  = 3'd2,
    FB_WRITE = 3'd3,
    FB_DONE  = 3'd4
  } fb_state_e;

endpackage

// File: rtl/l1_fill_buffer.sv
// rtl/l1_fill_buffer.sv - single-outstanding L1 miss fill: line read, beat assembly, one full-line SRAM write
module l1_fill_buffer
  import l1_fill_buffer_pkg::*;
#(
  parameter int LINE_BITS  = L1_LINE_BITS,
  parameter int BEAT_BITS  = L1_BEAT_BITS,
  parameter int INDEX_BITS = L1_INDEX_BITS,
  parameter int ADDR_BITS  = L1_ADDR_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_BITS-1:0]    req_addr,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_BITS-1:0]    mem_req_addr,
  input  logic                    beat_valid,
  output logic                    beat_ready,
  input  logic [BEAT_BITS-1:0]    beat_data,
  output logic                    sram_csb0,
  output logic [LINE_BITS/8-1:0]  sram_wmask0,
  output logic [INDEX_BITS-1:0]   sram_addr0,
  output logic [LINE_BITS-1:0]    sram_din0,
  output logic                    busy,
  output logic [INDEX_BITS-1:0]   fill_index,
  output logic                    fill_done
);

  localparam int BEATS       = LINE_BITS / BEAT_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int CNT_BITS    = $clog2(BEATS);
  localparam logic [ADDR_BITS-1:0] LINE_MASK = ~(ADDR_BITS'(LINE_BITS / 8 - 1));

  fb_state_e                 state_q, state_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [INDEX_BITS-1:0]     index_q;
  logic                      csb_q;
  logic [LINE_BITS/8-1:0]    wmask_q;
  logic [BEAT_BITS-1:0]      line_q [BEATS];
  logic                      beat_fire;

  assign beat_fire = (state_q == FB_FILL) && beat_valid;

  // SRAM controls are registered from the next state so WRITE sees them clean for its whole cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FB_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      index_q <= '0;
      csb_q   <= 1'b1;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csb_q   <= (state_d != FB_WRITE);
      wmask_q <= (state_d == FB_WRITE) ? '1 : '0;
      if (state_q == FB_IDLE && req_valid) begin
        addr_q  <= req_addr & LINE_MASK;
        index_q <= req_addr[OFFSET_BITS +: INDEX_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && beat_fire) begin
      line_q[cnt_q] <= beat_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FB_IDLE: begin
        cnt_d = '0;
        if (req_valid) state_d = FB_MREQ;
      end
      FB_MREQ: if (mem_req_ready) state_d = FB_FILL;
      FB_FILL: begin
        if (beat_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BITS'(BEATS - 1)) state_d = FB_WRITE;
        end
      end
      FB_WRITE: state_d = FB_DONE;
      FB_DONE:  state_d = FB_IDLE;
      default:  state_d = FB_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == FB_IDLE);
    mem_req_valid = (state_q == FB_MREQ);
    beat_ready    = (state_q == FB_FILL);
    busy          = (state_q != FB_IDLE);
    fill_done     = (state_q == FB_DONE);
  end

  always_comb begin
    sram_din0 = '0;
    for (int k = 0; k < BEATS; k++) begin
      sram_din0[k*BEAT_BITS +: BEAT_BITS] = line_q[k];
    end
  end

  assign mem_req_addr = addr_q;
  assign sram_csb0    = csb_q;
  assign sram_wmask0  = wmask_q;
  assign sram_addr0   = index_q;
  assign fill_index   = index_q;

endmodule

// File: tb/tb_l1_fill_buffer.sv
// tb/tb_l1_fill_buffer.sv - self-checking bench for l1_fill_buffer
module tb_l1_fill_buffer;

  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic          mem_req_valid, mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          beat_valid, beat_ready;
  logic [63:0]   beat_data;
  logic          sram_csb0;
  logic [127:0]  sram_wmask0;
  logic [7:0]    sram_addr0;
  logic [1023:0] sram_din0;
  logic          busy;
  logic [7:0]    fill_index;
  logic          fill_done;

  l1_fill_buffer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .busy(busy), .fill_index(fill_index), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          d;
    int          gap_mode;
    logic [63:0] base;
    logic [7:0]  exp_idx;
    logic [31:0] exp_maddr;
    int          exp_lat;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          csb_low_cnt = 0;
  int          done_cnt = 0;
  int          cur_gaps [NB];
  logic [63:0] cur_beats [NB];
  vec_t        vecs [5];

  always @(posedge clk) begin
    if (sram_csb0 === 1'b0) csb_low_cnt++;
    if (fill_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_beat_ready", beat_ready, 0);
    check("rst_csb", sram_csb0, 1);
    check("rst_wmask", (sram_wmask0 == '0), 1);
    check("rst_sram_addr", sram_addr0, 0);
    check("rst_busy", busy, 0);
    check("rst_fill_index", fill_index, 0);
    check("rst_fill_done", fill_done, 0);
  endtask

  task automatic do_fill(input logic [31:0] addr, input int d, input int exp_lat,
                         input logic [7:0] exp_idx, input logic [31:0] exp_maddr, input int abort_k);
    int cyc;
    int wcyc;
    int csb0;
    int done0;
    csb0  = csb_low_cnt;
    done0 = done_cnt;
    req_valid = 1'b1;
    req_addr  = addr;
    check("idle_req_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    step();
    cyc = 1;
    req_addr = $urandom;
    for (int i = 0; i <= d; i++) begin
      mem_req_ready = (i == d);
      beat_valid    = 1'b1;
      beat_data     = {$urandom, $urandom};
      check("mreq_valid", mem_req_valid, 1);
      check("mreq_addr", mem_req_addr, exp_maddr);
      check("mreq_req_ready", req_ready, 0);
      check("mreq_beat_ready", beat_ready, 0);
      check("mreq_busy", busy, 1);
      check("mreq_fill_index", fill_index, exp_idx);
      step();
      cyc++;
    end
    mem_req_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < cur_gaps[k]; g++) begin
        beat_valid = 1'b0;
        beat_data  = {$urandom, $urandom};
        check("gap_beat_ready", beat_ready, 1);
        check("gap_csb", sram_csb0, 1);
        step();
        cyc++;
      end
      beat_valid = 1'b1;
      beat_data  = cur_beats[k];
      check("fill_beat_ready", beat_ready, 1);
      check("fill_req_ready", req_ready, 0);
      check("fill_index", fill_index, exp_idx);
      step();
      cyc++;
      if (k == abort_k) begin
        beat_valid = 1'b0;
        req_valid  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        step();
        step();
        check("abort_no_write", csb_low_cnt - csb0, 0);
        check("abort_no_done", done_cnt - done0, 0);
        return;
      end
    end
    beat_valid = 1'b1;
    beat_data  = {$urandom, $urandom};
    wcyc = -1;
    for (int i = 0; i < 8 && wcyc < 0; i++) begin
      if (sram_csb0 === 1'b0) wcyc = cyc;
      else begin
        step();
        cyc++;
      end
    end
    check("write_latency", wcyc, exp_lat);
    if (wcyc >= 0) begin
      check("write_wmask", (sram_wmask0 == '1), 1);
      check("write_addr", sram_addr0, exp_idx);
      for (int k = 0; k < NB; k++) check("write_din", sram_din0[k*64 +: 64], cur_beats[k]);
      check("write_fill_done", fill_done, 0);
      check("write_busy", busy, 1);
      req_valid  = 1'b0;
      beat_valid = 1'b0;
      step();
      check("done_pulse", fill_done, 1);
      check("done_csb", sram_csb0, 1);
      check("done_busy", busy, 1);
      check("done_req_ready", req_ready, 0);
      step();
      check("after_done", fill_done, 0);
      check("after_busy", busy, 0);
      check("after_req_ready", req_ready, 1);
    end
    check("one_write", csb_low_cnt - csb0, 1);
    check("one_done", done_cnt - done0, 1);
  endtask

  initial begin
    int          gsum;
    logic [31:0] a;
    int          d;

    vecs[0] = '{32'h0000_4A80, 0, 0, 64'h0,                  8'h95, 32'h0000_4A80, 18};
    vecs[1] = '{32'h0000_4A80, 0, 1, 64'h0,                  8'h95, 32'h0000_4A80, 34};
    vecs[2] = '{32'h0000_4AFF, 5, 0, 64'hA5A5_0000_0000_0000, 8'h95, 32'h0000_4A80, 23};
    vecs[3] = '{32'hFFFF_FFFF, 2, 0, 64'h1000,               8'hFF, 32'hFFFF_FF80, 20};
    vecs[4] = '{32'h0000_007F, 1, 1, 64'h55,                 8'h00, 32'h0000_0000, 35};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b0;
    beat_valid = 1'b0; beat_data = '0;
    step();
    step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      for (int k = 0; k < NB; k++) begin
        cur_gaps[k]  = vecs[i].gap_mode;
        cur_beats[k] = vecs[i].base + 64'(k);
      end
      do_fill(vecs[i].addr, vecs[i].d, vecs[i].exp_lat, vecs[i].exp_idx, vecs[i].exp_maddr, -1);
    end

    for (int k = 0; k < NB; k++) begin
      cur_gaps[k]  = 0;
      cur_beats[k] = 64'(k);
    end
    do_fill(32'h0000_4A80, 0, 18, 8'h95, 32'h0000_4A80, 9);
    do_fill(32'h0000_4A80, 0, 18, 8'h95, 32'h0000_4A80, -1);

    for (int r = 0; r < 8; r++) begin
      a = $urandom;
      d = $urandom_range(0, 4);
      gsum = 0;
      for (int k = 0; k < NB; k++) begin
        cur_gaps[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        gsum        += cur_gaps[k];
        cur_beats[k] = {$urandom, $urandom};
      end
      do_fill(a, d, 18 + d + gsum, a[14:7], a & 32'hFFFF_FF80, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
